tau_dot_seq: RTL and testbench

Sequencer that computes dot products on a shared serial tau MAC engine. It accepts (a, b) operand pairs over a valid/ready stream, with in_last marking the end of a vector. For each pair it issues one product to the engine, waits for completion and adds the product into a wide vector accumulator. When the vector ends, it presents the sum, element count and status flags on a valid/ready output.

---
 rtl/tau_dot_seq.sv | 155 +++++++++++++++
 tb/tb_tau_dot_seq.sv | 278 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/tau_dot_seq.sv
// Dot-product sequencer in front of a shared serial tau MAC engine.
// Each accepted (a, b) pair is either skipped (a zero operand) or issued to the engine.
// Engine products are summed into a wide accumulator.
// At the end of a vector the sum, element count and status flags are offered on a valid/ready output.
module tau_dot_seq #(
  parameter int BITWIDTH = 8,
  parameter int ACC_W    = 24,
  parameter int CNT_W    = 8,
  parameter int TIMEOUT  = 16
) (
  input  logic                  clk,
  input  logic                  reset_n,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [BITWIDTH-1:0]   in_a,
  input  logic [BITWIDTH-1:0]   in_b,
  input  logic                  in_last,
  output logic                  eng_start,
  output logic [BITWIDTH-1:0]   eng_a,
  output logic [BITWIDTH-1:0]   eng_b,
  input  logic                  eng_done,
  input  logic [2*BITWIDTH-1:0] eng_result,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [ACC_W-1:0]      out_data,
  output logic [CNT_W-1:0]      out_count,
  output logic                  out_ovf,
  output logic                  out_err
);

  localparam int WCNT_W = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
  localparam int PAD_W  = ACC_W + 1 - 2 * BITWIDTH;

  typedef enum logic [1:0] {IDLE, ISSUE, WAIT, OUT} state_t;

  state_t              state;
  state_t              state_nx;
  logic [ACC_W-1:0]    acc;
  logic [CNT_W-1:0]    count;
  logic                ovf;
  logic                err;
  logic                last_q;
  logic [WCNT_W-1:0]   wait_cnt;
  logic                handshake;
  logic                zero_pair;
  logic                wait_expired;
  logic [ACC_W:0]      sum;

  // One extra bit above the accumulator captures the carry that marks a wrap
  assign sum          = {1'b0, acc} + {{PAD_W{1'b0}}, eng_result};
  assign handshake    = in_valid & in_ready;
  assign zero_pair    = (in_a == '0) || (in_b == '0);
  assign wait_expired = (wait_cnt == WCNT_W'(TIMEOUT - 1));

  // Result fields are only visible while the result is being offered
  assign out_data  = out_valid ? acc   : '0;
  assign out_count = out_valid ? count : '0;
  assign out_ovf   = out_valid & ovf;
  assign out_err   = out_valid & err;

  // State register; reset abandons any engine operation in flight
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state <= IDLE;
    end else begin
      state <= state_nx;
    end
  end

  // Next-state and handshake outputs; zero pairs bypass the engine entirely
  always_comb begin
    state_nx  = state;
    in_ready  = 1'b0;
    eng_start = 1'b0;
    out_valid = 1'b0;
    case (state)
      IDLE: begin
        in_ready = reset_n;
        if (handshake) begin
          if (zero_pair) begin
            state_nx = in_last ? OUT : IDLE;
          end else begin
            state_nx = ISSUE;
          end
        end
      end
      ISSUE: begin
        eng_start = 1'b1;
        state_nx  = WAIT;
      end
      WAIT: begin
        if (eng_done || wait_expired) begin
          state_nx = last_q ? OUT : IDLE;
        end
      end
      OUT: begin
        out_valid = 1'b1;
        if (out_ready) begin
          state_nx = IDLE;
        end
      end
      default: state_nx = IDLE;
    endcase
  end

  // Operand latch, accumulation, wait timer and sticky flags
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      acc      <= '0;
      count    <= '0;
      ovf      <= 1'b0;
      err      <= 1'b0;
      last_q   <= 1'b0;
      eng_a    <= '0;
      eng_b    <= '0;
      wait_cnt <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (handshake) begin
            eng_a  <= in_a;
            eng_b  <= in_b;
            last_q <= in_last;
            count  <= count + 1'b1;
          end
        end
        ISSUE: begin
          wait_cnt <= '0;
        end
        WAIT: begin
          if (eng_done) begin
            acc <= sum[ACC_W-1:0];
            if (sum[ACC_W]) begin
              ovf <= 1'b1;
            end
          end else if (wait_expired) begin
            err <= 1'b1;
          end else begin
            wait_cnt <= wait_cnt + 1'b1;
          end
        end
        OUT: begin
          if (out_ready) begin
            acc   <= '0;
            count <= '0;
            ovf   <= 1'b0;
            err   <= 1'b0;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_tau_dot_seq.sv
// Directed self-checking bench for tau_dot_seq.
// A 24-bit and a 17-bit accumulator instance run in lockstep, each with its own engine model.
module tb_tau_dot_seq;

  logic        clk = 1'b0;
  logic        reset_n = 1'b0;
  logic        in_valid = 1'b0;
  logic [7:0]  in_a = '0;
  logic [7:0]  in_b = '0;
  logic        in_last = 1'b0;
  logic        out_ready = 1'b0;
  logic        eng_mute = 1'b0;
  logic        late_done = 1'b0;

  logic        in_ready, eng_start, eng_done, out_valid, out_ovf, out_err;
  logic [7:0]  eng_a, eng_b, out_count;
  logic [15:0] eng_result;
  logic [23:0] out_data;

  logic        in_ready17, eng_start17, eng_done17, out_valid17, out_ovf17, out_err17;
  logic [7:0]  eng_a17, eng_b17, out_count17;
  logic [15:0] eng_result17;
  logic [16:0] out_data17;

  int vectors = 0;
  int errors = 0;
  int cyc = 0;
  int start_cnt = 0;
  int start_cyc = 0;
  logic [7:0] start_a = '0;
  logic [7:0] start_b = '0;
  int hs_cyc = 0;
  int out_cyc = 0;

  logic        m_busy = 1'b0, m_done = 1'b0;
  int          m_cnt = 0;
  logic [15:0] m_prod = '0, m_res = '0;
  logic        m_busy17 = 1'b0, m_done17 = 1'b0;
  int          m_cnt17 = 0;
  logic [15:0] m_prod17 = '0, m_res17 = '0;

  always #5 clk = ~clk;

  tau_dot_seq #(.BITWIDTH(8), .ACC_W(24), .CNT_W(8), .TIMEOUT(16)) dut (
    .clk(clk), .reset_n(reset_n), .in_valid(in_valid), .in_ready(in_ready),
    .in_a(in_a), .in_b(in_b), .in_last(in_last),
    .eng_start(eng_start), .eng_a(eng_a), .eng_b(eng_b),
    .eng_done(eng_done), .eng_result(eng_result),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
    .out_count(out_count), .out_ovf(out_ovf), .out_err(out_err)
  );

  tau_dot_seq #(.BITWIDTH(8), .ACC_W(17), .CNT_W(8), .TIMEOUT(16)) dut17 (
    .clk(clk), .reset_n(reset_n), .in_valid(in_valid), .in_ready(in_ready17),
    .in_a(in_a), .in_b(in_b), .in_last(in_last),
    .eng_start(eng_start17), .eng_a(eng_a17), .eng_b(eng_b17),
    .eng_done(eng_done17), .eng_result(eng_result17),
    .out_valid(out_valid17), .out_ready(out_ready), .out_data(out_data17),
    .out_count(out_count17), .out_ovf(out_ovf17), .out_err(out_err17)
  );

  assign eng_done     = m_done | late_done;
  assign eng_result   = m_res;
  assign eng_done17   = m_done17 | late_done;
  assign eng_result17 = m_res17;

  // Engine model: answers with the product four cycles after start unless muted
  always @(posedge clk) begin
    m_done <= 1'b0;
    if (eng_start && !eng_mute) begin
      m_busy <= 1'b1;
      m_cnt  <= 1;
      m_prod <= eng_a * eng_b;
    end else if (m_busy) begin
      if (m_cnt == 3) begin
        m_done <= 1'b1;
        m_busy <= 1'b0;
        m_res  <= m_prod;
      end else begin
        m_cnt <= m_cnt + 1;
      end
    end
  end

  // Same engine model for the narrow-accumulator instance
  always @(posedge clk) begin
    m_done17 <= 1'b0;
    if (eng_start17 && !eng_mute) begin
      m_busy17 <= 1'b1;
      m_cnt17  <= 1;
      m_prod17 <= eng_a17 * eng_b17;
    end else if (m_busy17) begin
      if (m_cnt17 == 3) begin
        m_done17 <= 1'b1;
        m_busy17 <= 1'b0;
        m_res17  <= m_prod17;
      end else begin
        m_cnt17 <= m_cnt17 + 1;
      end
    end
  end

  // Cycle counter and eng_start observer
  always @(posedge clk) begin
    cyc <= cyc + 1;
    if (eng_start) begin
      start_cnt <= start_cnt + 1;
      start_cyc <= cyc + 1;
      start_a   <= eng_a;
      start_b   <= eng_b;
    end
  end

  task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    vectors++;
    if (observed !== expected) begin
      errors++;
      $display("[TB] FAIL %s: got %0d, expected %0d", tag, observed, expected);
    end
  endtask

  // Offer one pair and return just after the edge on which it was accepted
  task automatic applyStimulus(input logic [7:0] a, input logic [7:0] b, input logic last);
    int n;
    n = 0;
    @(negedge clk);
    in_valid = 1'b1;
    in_a     = a;
    in_b     = b;
    in_last  = last;
    while (!in_ready && n < 200) begin
      @(negedge clk);
      n++;
    end
    if (n >= 200) checkOutput("in_ready_timeout", 0, 1);
    @(posedge clk);
    #1;
    hs_cyc   = cyc;
    in_valid = 1'b0;
    in_a     = 8'hA5;
    in_b     = 8'h5A;
    in_last  = 1'b0;
  endtask

  task automatic waitOut();
    int n;
    n = 0;
    while (!out_valid && n < 200) begin
      @(negedge clk);
      n++;
    end
    if (n >= 200) checkOutput("out_valid_timeout", 0, 1);
    out_cyc = cyc;
  endtask

  task automatic acceptOut();
    @(negedge clk);
    out_ready = 1'b1;
    @(posedge clk);
    #1;
    out_ready = 1'b0;
  endtask

  initial begin
    int s0;
    int hs_first;

    // Reset values
    repeat (3) @(negedge clk);
    checkOutput("rst_in_ready", in_ready, 0);
    checkOutput("rst_out_valid", out_valid, 0);
    checkOutput("rst_eng_start", eng_start, 0);
    checkOutput("rst_out_data", out_data, 0);
    checkOutput("rst_eng_a", eng_a, 0);
    reset_n = 1'b1;
    @(negedge clk);
    checkOutput("idle_in_ready", in_ready, 1);

    // (3,5),(2,7),(1,1 last) -> 30
    s0 = start_cnt;
    applyStimulus(8'd3, 8'd5, 1'b0);
    applyStimulus(8'd2, 8'd7, 1'b0);
    applyStimulus(8'd1, 8'd1, 1'b1);
    waitOut();
    checkOutput("t1_start_cycle", start_cyc, hs_cyc + 1);
    checkOutput("t1_latency", out_cyc - hs_cyc, 5);
    checkOutput("t1_data", out_data, 30);
    checkOutput("t1_count", out_count, 3);
    checkOutput("t1_ovf", out_ovf, 0);
    checkOutput("t1_err", out_err, 0);
    checkOutput("t1_starts", start_cnt - s0, 3);
    acceptOut();

    // (0,9),(4,0),(6,6 last) -> zero-skip, one engine use
    s0 = start_cnt;
    applyStimulus(8'd0, 8'd9, 1'b0);
    hs_first = hs_cyc;
    applyStimulus(8'd4, 8'd0, 1'b0);
    checkOutput("t2_back_to_back", hs_cyc - hs_first, 1);
    applyStimulus(8'd6, 8'd6, 1'b1);
    waitOut();
    checkOutput("t2_starts", start_cnt - s0, 1);
    checkOutput("t2_eng_a", start_a, 6);
    checkOutput("t2_eng_b", start_b, 6);
    checkOutput("t2_data", out_data, 36);
    checkOutput("t2_count", out_count, 3);
    acceptOut();

    // Four (255,255): 260100 fits 24 bits, wraps to 129028 in 17 bits
    for (int i = 0; i < 4; i++) applyStimulus(8'd255, 8'd255, (i == 3));
    waitOut();
    checkOutput("t3_data24", out_data, 260100);
    checkOutput("t3_ovf24", out_ovf, 0);
    checkOutput("t3_valid17", out_valid17, 1);
    checkOutput("t3_data17", out_data17, 129028);
    checkOutput("t3_count17", out_count17, 4);
    checkOutput("t3_ovf17", out_ovf17, 1);
    acceptOut();

    // Backpressure on the result
    applyStimulus(8'd255, 8'd255, 1'b1);
    waitOut();
    for (int i = 0; i < 5; i++) begin
      checkOutput("t4_hold_valid", out_valid, 1);
      checkOutput("t4_hold_data", out_data, 65025);
      checkOutput("t4_hold_in_ready", in_ready, 0);
      @(negedge clk);
    end
    acceptOut();
    @(negedge clk);
    checkOutput("t4_after_valid", out_valid, 0);
    checkOutput("t4_after_data", out_data, 0);
    checkOutput("t4_after_in_ready", in_ready, 1);

    // Timeout on the second element, then a stray late eng_done
    applyStimulus(8'd2, 8'd3, 1'b0);
    applyStimulus(8'd5, 8'd5, 1'b1);
    eng_mute = 1'b1;
    waitOut();
    eng_mute = 1'b0;
    checkOutput("t5_wait_cycles", out_cyc - hs_cyc, 17);
    checkOutput("t5_data", out_data, 6);
    checkOutput("t5_count", out_count, 2);
    checkOutput("t5_err", out_err, 1);
    late_done = 1'b1;
    @(negedge clk);
    late_done = 1'b0;
    @(negedge clk);
    checkOutput("t5_late_done_data", out_data, 6);
    acceptOut();

    // Reset while waiting on the engine
    applyStimulus(8'd7, 8'd7, 1'b1);
    @(negedge clk);
    @(negedge clk);
    reset_n = 1'b0;
    #1;
    checkOutput("t6_rst_in_ready", in_ready, 0);
    checkOutput("t6_rst_eng_start", eng_start, 0);
    checkOutput("t6_rst_eng_a", eng_a, 0);
    checkOutput("t6_rst_out_valid", out_valid, 0);
    repeat (2) @(negedge clk);
    reset_n = 1'b1;
    repeat (8) @(negedge clk);
    checkOutput("t6_idle_valid", out_valid, 0);
    applyStimulus(8'd1, 8'd2, 1'b1);
    waitOut();
    checkOutput("t6_data", out_data, 2);
    checkOutput("t6_count", out_count, 1);
    checkOutput("t6_ovf", out_ovf, 0);
    checkOutput("t6_err", out_err, 0);
    acceptOut();

    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end

endmodule
